dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-requester arbiter and sequencer for the shared 32-bit single-port data memory in the TMR RISC-V core. The requesters are the core load/store path and the scrub/debug port. The block performs round-robin arbitration with optional bus locking and registers the winning command into a one-deep issue stage that drives the memory's WE/A/WD. It captures the memory's combinational RD and returns it to the issuing requester with a valid pulse. It also rejects out-of-range addresses.

## Interface
- DEPTH, 32, number of memory words; legal addresses are 0..DEPTH-1 (word index, same as memory A)
- LOCK_MAX, 8, maximum consecutive locked grants before the lock is forcibly released (≥1)
- clk  in  1  clock, all state updates on posedge
- rst_in  in  1  synchronous, active-low reset
- rN_req  in  1  requester N (N=0,1) command request; held until rN_gnt
- rN_we  in  1  1 = write, 0 = read
- rN_addr  in  32  word address
- rN_wdata  in  32  write data
- rN_lock  in  1  keep ownership after this grant
- rN_gnt  out  1  combinational accept; the command is taken on this clock edge
- rN_rvalid  out  1  one-cycle pulse: response for requester N's oldest accepted command
- rN_rdata  out  32  read data (0 for writes and errors), valid with rN_rvalid
- rN_err  out  1  with rN_rvalid: address ≥ DEPTH
- mem_we  out  1  memory write enable
- mem_a  out  32  memory address
- mem_wd  out  32  memory write data
- mem_rd  in  32  memory read data (combinational from mem_a)

## Operation
- **State:** rr_last (last granted requester), lock_act, lock_owner, lock_cnt[$clog2(LOCK_MAX+1)], issue stage (cmd_v, cmd_id, cmd_we, cmd_a, cmd_wd, cmd_err), response stage (rsp_v, rsp_id, rsp_data, rsp_err).
- **Arbitration (combinational, every cycle with rst_in=1):**
  - If lock_act, only lock_owner is eligible.
  - Otherwise, if both requesters ask, the one ≠ rr_last wins. If one asks, it wins.
  - At most one gnt per cycle. Both gnt are 0 while rst_in=0.
- **On a grant edge:**
  - The issue stage loads {winner, we, addr, wdata, addr≥DEPTH}, cmd_v=1, and rr_last=winner.
  - With no grant, cmd_v=0.
- **Lock:**
  - A grant with lock=1 and lock_act=0 sets lock_act=1, lock_owner=winner, lock_cnt=1.
  - An owner grant with lock=1 increments lock_cnt.
  - An owner grant with lock=0 clears lock_act.
  - When lock_cnt would reach LOCK_MAX, lock_act clears instead, so the next arbitration is unlocked and round-robin favours the other requester.
- **Issue cycle (cmd_v=1):**
  - mem_a=cmd_a and mem_wd=cmd_wd.
  - mem_we = rst_in & cmd_v & cmd_we & ~cmd_err (combinational gating, so no write occurs in a reset cycle).
  - With cmd_v=0: mem_we=0, mem_a=0, mem_wd=0.
- **Response edge:**
  - rsp_v<=cmd_v, rsp_id<=cmd_id, rsp_err<=cmd_err.
  - rsp_data<=mem_rd if the command is a read without error, else 0.
  - rN_rvalid = rsp_v & (rsp_id==N), and rN_rdata/rN_err mirror rsp_* when valid, else 0.
- **Write-then-read:** one command issues per cycle and the memory write commits at the issue-cycle edge. A read issued the cycle after a write to the same address returns the new data.
- **Address width:** rN_addr is compared as a full 32-bit unsigned value against DEPTH. No truncation or wrap is applied.

## Timing
- **Reset (rst_in=0 at posedge):** rr_last=1, so r0 wins the first tie. lock_act=0, lock_cnt=0, cmd_v=0, rsp_v=0.
- **Outputs during and after reset:** all gnt/rvalid/err/rdata/mem_* are 0 from that edge. gnt and mem_we are also 0 combinationally during the reset cycle.
- **Reset mid-operation:** in-flight issue and response stages are discarded and no rvalid is produced for them.
- **Latency:** request accepted (gnt) in cycle T, memory access in T+1, rvalid/rdata in T+2.
- **Throughput:** one command per cycle, back-to-back, with no bubbles.
- **Requester hold rule:** a requester must keep req and its fields stable until gnt. It may change them in the cycle after gnt.
- **Lock deadlock avoidance:** a lock owner that deasserts req does not release the lock. The LOCK_MAX counter covers grants only; a stalled owner blocks the other requester until it issues lock=0.

## Test plan
- **Reset and tie-breaking:** reset, then r0 and r1 both read, addr 2 and 3 (mem[2]=0x8, mem[3]=0x55) held continuously -> gnt order r0,r1,r0,r1…; r0_rvalid with rdata 0x8 two cycles after each r0 gnt; r1 gets 0x55.
- **Write then read:** r0 writes 0xAAAA5555 to addr 1, then reads addr 1 in the next cycle -> mem_we=1 with mem_a=1 one cycle after the write gnt; the read returns 0xAAAA5555.
- **Lock exclusivity:** r1 issues 3 locked writes plus 1 unlocked write while r0 requests continuously -> r0_gnt stays 0 until the cycle after r1's unlocked grant, then r0 wins.
- **Forced release:** with LOCK_MAX=8, r1 holds lock=1 indefinitely and r0 requests -> after r1's 8th consecutive grant, the next grant goes to r0.
- **Out of range:** r0 writes addr 32 (DEPTH=32) -> mem_we stays 0 and r0_err=1 with rdata 0. An out-of-range read of addr 0xFFFFFFFF behaves the same.
- **Reset mid-transaction:** assert rst_in=0 in the issue cycle of a write to addr 0 -> memory is unchanged, no rvalid, and the first post-reset tie is granted to r0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-requester round-robin arbiter with lock and one-deep issue stage for the shared data memory
// Round-robin with optional locking feeds a registered issue stage; the memory's combinational RD is captured one cycle later.
module dmem_arbiter #(
  parameter int DEPTH    = 32,
  parameter int LOCK_MAX = 8
) (
  input  logic        clk,
  input  logic        rst_in,
  input  logic        r0_req,
  input  logic        r0_we,
  input  logic [31:0] r0_addr,
  input  logic [31:0] r0_wdata,
  input  logic        r0_lock,
  output logic        r0_gnt,
  output logic        r0_rvalid,
  output logic [31:0] r0_rdata,
  output logic        r0_err,
  input  logic        r1_req,
  input  logic        r1_we,
  input  logic [31:0] r1_addr,
  input  logic [31:0] r1_wdata,
  input  logic        r1_lock,
  output logic        r1_gnt,
  output logic        r1_rvalid,
  output logic [31:0] r1_rdata,
  output logic        r1_err,
  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);
  localparam int          CW         = $clog2(LOCK_MAX + 1);
  localparam logic [31:0] DEPTH_W    = 32'(DEPTH);
  localparam logic [CW-1:0] LOCK_MAX_W = CW'(LOCK_MAX);

  logic          rr_last_q, rr_last_d;
  logic          lock_act_q, lock_act_d;
  logic          lock_owner_q, lock_owner_d;
  logic [CW-1:0] lock_cnt_q, lock_cnt_d;
  logic          cmd_v_q, cmd_id_q, cmd_we_q, cmd_err_q;
  logic [31:0]   cmd_a_q, cmd_wd_q;
  logic          rsp_v_q, rsp_id_q, rsp_err_q;
  logic [31:0]   rsp_data_q, rsp_data_d;

  logic          elig0, elig1, gnt_any, win;
  logic          win_we, win_lock;
  logic [31:0]   win_addr, win_wdata;

  always_comb begin
    elig0     = r0_req & (~lock_act_q | ~lock_owner_q);
    elig1     = r1_req & (~lock_act_q | lock_owner_q);
    gnt_any   = rst_in & (elig0 | elig1);
    // On a tie the requester that did not win last time goes first.
    win       = (elig0 & elig1) ? ~rr_last_q : elig1;
    r0_gnt    = gnt_any & ~win;
    r1_gnt    = gnt_any & win;
    win_we    = win ? r1_we    : r0_we;
    win_lock  = win ? r1_lock  : r0_lock;
    win_addr  = win ? r1_addr  : r0_addr;
    win_wdata = win ? r1_wdata : r0_wdata;
  end

  always_comb begin
    rr_last_d    = rr_last_q;
    lock_act_d   = lock_act_q;
    lock_owner_d = lock_owner_q;
    lock_cnt_d   = lock_cnt_q;
    if (gnt_any) begin
      rr_last_d = win;
      if (lock_act_q) begin
        // Reaching LOCK_MAX releases instead of counting, so the other side gets the next tie.
        if (win_lock && ((lock_cnt_q + CW'(1)) < LOCK_MAX_W)) begin
          lock_cnt_d = lock_cnt_q + CW'(1);
        end else begin
          lock_act_d = 1'b0;
          lock_cnt_d = '0;
        end
      end else if (win_lock && (LOCK_MAX > 1)) begin
        lock_act_d   = 1'b1;
        lock_owner_d = win;
        lock_cnt_d   = CW'(1);
      end
    end
  end

  assign rsp_data_d = (cmd_v_q & ~cmd_we_q & ~cmd_err_q) ? mem_rd : 32'h0;

  always_ff @(posedge clk) begin
    if (!rst_in) begin
      rr_last_q    <= 1'b1;
      lock_act_q   <= 1'b0;
      lock_owner_q <= 1'b0;
      lock_cnt_q   <= '0;
      cmd_v_q      <= 1'b0;
      cmd_id_q     <= 1'b0;
      cmd_we_q     <= 1'b0;
      cmd_err_q    <= 1'b0;
      cmd_a_q      <= '0;
      cmd_wd_q     <= '0;
      rsp_v_q      <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_data_q   <= '0;
    end else begin
      rr_last_q    <= rr_last_d;
      lock_act_q   <= lock_act_d;
      lock_owner_q <= lock_owner_d;
      lock_cnt_q   <= lock_cnt_d;
      cmd_v_q      <= gnt_any;
      cmd_id_q     <= win;
      cmd_we_q     <= win_we;
      cmd_err_q    <= (win_addr >= DEPTH_W);
      cmd_a_q      <= win_addr;
      cmd_wd_q     <= win_wdata;
      rsp_v_q      <= cmd_v_q;
      rsp_id_q     <= cmd_id_q;
      rsp_err_q    <= cmd_err_q;
      rsp_data_q   <= rsp_data_d;
    end
  end

  assign mem_we    = rst_in & cmd_v_q & cmd_we_q & ~cmd_err_q;
  assign mem_a     = cmd_v_q ? cmd_a_q  : 32'h0;
  assign mem_wd    = cmd_v_q ? cmd_wd_q : 32'h0;

  assign r0_rvalid = rsp_v_q & ~rsp_id_q;
  assign r1_rvalid = rsp_v_q & rsp_id_q;
  assign r0_rdata  = r0_rvalid ? rsp_data_q : 32'h0;
  assign r1_rdata  = r1_rvalid ? rsp_data_q : 32'h0;
  assign r0_err    = r0_rvalid & rsp_err_q;
  assign r1_err    = r1_rvalid & rsp_err_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - vector table plus scoreboard bench for dmem_arbiter
module tb_dmem_arbiter;
  logic        clk = 1'b0;
  logic        rst_in;
  logic        r0_req, r0_we, r0_lock, r1_req, r1_we, r1_lock;
  logic [31:0] r0_addr, r0_wdata, r1_addr, r1_wdata;
  logic        r0_gnt, r0_rvalid, r0_err, r1_gnt, r1_rvalid, r1_err;
  logic [31:0] r0_rdata, r1_rdata;
  logic        mem_we;
  logic [31:0] mem_a, mem_wd, mem_rd;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [31:0] mem     [0:31];
  logic [31:0] ref_mem [0:31];

  typedef struct {
    logic        id;
    logic [31:0] data;
    logic        err;
    int          cyc;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    string       name;
    logic        q0, w0, k0;
    logic [31:0] a0, d0;
    logic        q1, w1, k1;
    logic [31:0] a1, d1;
    logic        g0, g1;
    logic        cm, ewe;
    logic [31:0] ea;
  } vec_t;
  vec_t tbl[$];

  dmem_arbiter #(.DEPTH(32), .LOCK_MAX(8)) dut (
    .clk(clk), .rst_in(rst_in),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata), .r0_lock(r0_lock),
    .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata), .r0_err(r0_err),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata), .r1_lock(r1_lock),
    .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata), .r1_err(r1_err),
    .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Single-port memory: combinational read, write at the clock edge.
  assign mem_rd = (mem_a < 32'd32) ? mem[mem_a[4:0]] : 32'h0;
  always @(posedge clk) if (mem_we) mem[mem_a[4:0]] <= mem_wd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: expectations pushed on gnt, popped on rvalid.
  always @(negedge clk) begin
    exp_t        e;
    logic        id, we, err;
    logic [31:0] a, d;
    if (!rst_in) begin
      sbq.delete();
    end else begin
      if (!r0_rvalid) begin
        check("r0 idle rdata", r0_rdata, 32'h0);
        check("r0 idle err", {31'b0, r0_err}, 32'h0);
      end
      if (!r1_rvalid) begin
        check("r1 idle rdata", r1_rdata, 32'h0);
        check("r1 idle err", {31'b0, r1_err}, 32'h0);
      end
      if (r0_rvalid || r1_rvalid) begin
        check("single rvalid", {31'b0, r0_rvalid & r1_rvalid}, 32'h0);
        if (sbq.size() == 0) begin
          check("spurious rvalid", 32'h1, 32'h0);
        end else begin
          e = sbq.pop_front();
          check("rsp id", {31'b0, r1_rvalid}, {31'b0, e.id});
          check("rsp rdata", r1_rvalid ? r1_rdata : r0_rdata, e.data);
          check("rsp err", {31'b0, r1_rvalid ? r1_err : r0_err}, {31'b0, e.err});
          check("rsp latency", 32'(cyc), 32'(e.cyc + 2));
        end
      end
      if (r0_gnt || r1_gnt) begin
        id  = r1_gnt;
        we  = id ? r1_we : r0_we;
        a   = id ? r1_addr : r0_addr;
        d   = id ? r1_wdata : r0_wdata;
        err = (a >= 32'd32);
        e.id   = id;
        e.err  = err;
        e.cyc  = cyc;
        e.data = (we || err) ? 32'h0 : ref_mem[a[4:0]];
        if (we && !err) ref_mem[a[4:0]] = d;
        sbq.push_back(e);
      end
    end
  end

  function automatic vec_t mk(input string n,
                              input logic q0, input logic w0, input logic k0,
                              input logic [31:0] a0, input logic [31:0] d0,
                              input logic q1, input logic w1, input logic k1,
                              input logic [31:0] a1, input logic [31:0] d1,
                              input logic g0, input logic g1,
                              input logic cm, input logic ewe, input logic [31:0] ea);
    vec_t v;
    v.name = n;
    v.q0 = q0; v.w0 = w0; v.k0 = k0; v.a0 = a0; v.d0 = d0;
    v.q1 = q1; v.w1 = w1; v.k1 = k1; v.a1 = a1; v.d1 = d1;
    v.g0 = g0; v.g1 = g1; v.cm = cm; v.ewe = ewe; v.ea = ea;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    r0_req = v.q0; r0_we = v.w0; r0_lock = v.k0; r0_addr = v.a0; r0_wdata = v.d0;
    r1_req = v.q1; r1_we = v.w1; r1_lock = v.k1; r1_addr = v.a1; r1_wdata = v.d1;
  endtask

  task automatic apply(input vec_t v);
    drive(v);
    @(negedge clk);
    check({v.name, " r0_gnt"}, {31'b0, r0_gnt}, {31'b0, v.g0});
    check({v.name, " r1_gnt"}, {31'b0, r1_gnt}, {31'b0, v.g1});
    if (v.cm) begin
      check({v.name, " mem_we"}, {31'b0, mem_we}, {31'b0, v.ewe});
      check({v.name, " mem_a"}, mem_a, v.ea);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] old0;
    vec_t        idle;

    for (int i = 0; i < 32; i++) begin
      mem[i]     = 32'h1000 + 32'(i);
      ref_mem[i] = 32'h1000 + 32'(i);
    end
    mem[2] = 32'h8;  ref_mem[2] = 32'h8;
    mem[3] = 32'h55; ref_mem[3] = 32'h55;

    idle = mk("idle", 0,0,0,0,0, 0,0,0,0,0, 0,0, 0,0,0);

    // Tie-breaking from reset: continuous reads of addr 2 and 3.
    for (int i = 0; i < 6; i++)
      tbl.push_back(mk("tie", 1,0,0,2,0, 1,0,0,3,0, (i % 2) == 0, (i % 2) == 1, 0,0,0));
    tbl.push_back(idle);
    // Write then read the same word.
    tbl.push_back(mk("wr", 1,1,0,1,32'hAAAA5555, 0,0,0,0,0, 1,0, 0,0,0));
    tbl.push_back(mk("rd_after_wr", 1,0,0,1,0, 0,0,0,0,0, 1,0, 1,1,1));
    tbl.push_back(idle);
    // Lock exclusivity: r1 three locked writes then one unlocked.
    tbl.push_back(mk("lk1", 1,0,0,4,0, 1,1,1,5,32'h100, 0,1, 0,0,0));
    tbl.push_back(mk("lk2", 1,0,0,4,0, 1,1,1,6,32'h101, 0,1, 1,1,5));
    tbl.push_back(mk("lk3", 1,0,0,4,0, 1,1,1,7,32'h102, 0,1, 1,1,6));
    tbl.push_back(mk("lk4", 1,0,0,4,0, 1,1,0,8,32'h103, 0,1, 1,1,7));
    tbl.push_back(mk("lk5", 1,0,0,4,0, 1,0,0,5,0, 1,0, 1,1,8));
    tbl.push_back(mk("lk6", 0,0,0,0,0, 1,0,0,5,0, 0,1, 1,0,4));
    // Forced release after LOCK_MAX locked grants.
    tbl.push_back(mk("fr1", 0,0,0,0,0, 1,0,1,9,0, 0,1, 0,0,0));
    for (int i = 2; i <= 8; i++)
      tbl.push_back(mk("fr_hold", 1,0,0,10,0, 1,0,1,9,0, 0,1, 0,0,0));
    tbl.push_back(mk("fr_release", 1,0,0,10,0, 1,0,1,9,0, 1,0, 0,0,0));
    tbl.push_back(mk("fr_relock", 0,0,0,0,0, 1,0,1,9,0, 0,1, 0,0,0));
    tbl.push_back(mk("fr_unlock", 0,0,0,0,0, 1,0,0,9,0, 0,1, 0,0,0));
    tbl.push_back(idle);
    // Out-of-range and boundary addresses.
    tbl.push_back(mk("oor_wr", 1,1,0,32,32'hDEAD, 0,0,0,0,0, 1,0, 0,0,0));
    tbl.push_back(mk("oor_rd", 1,0,0,32'hFFFFFFFF,0, 0,0,0,0,0, 1,0, 1,0,32));
    tbl.push_back(mk("top_wr", 0,0,0,0,0, 1,1,0,31,32'h31, 0,1, 1,0,32'hFFFFFFFF));
    tbl.push_back(mk("top_rd", 1,0,0,31,0, 0,0,0,0,0, 1,0, 1,1,31));
    tbl.push_back(idle);
    tbl.push_back(idle);
    tbl.push_back(idle);

    // Reset: a pending request must not be granted, outputs idle.
    rst_in = 1'b0;
    drive(idle);
    r0_req = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset r0_gnt", {31'b0, r0_gnt}, 32'h0);
    check("reset mem_we", {31'b0, mem_we}, 32'h0);
    check("reset mem_a", mem_a, 32'h0);
    check("reset rvalid", {30'b0, r0_rvalid, r1_rvalid}, 32'h0);
    @(posedge clk);
    #1;
    rst_in = 1'b1;
    r0_req = 1'b0;

    foreach (tbl[i]) apply(tbl[i]);

    // Reset during the issue cycle of a write to addr 0.
    old0 = ref_mem[0];
    apply(mk("rst_wr", 1,1,0,0,32'h0BADC0DE, 0,0,0,0,0, 1,0, 0,0,0));
    rst_in = 1'b0;
    drive(mk("rst_tie", 1,0,0,2,0, 1,0,0,3,0, 0,0, 0,0,0));
    @(negedge clk);
    check("rst issue mem_we", {31'b0, mem_we}, 32'h0);
    check("rst r0_gnt", {31'b0, r0_gnt}, 32'h0);
    check("rst r1_gnt", {31'b0, r1_gnt}, 32'h0);
    @(posedge clk);
    #1;
    ref_mem[0] = old0;
    rst_in = 1'b1;
    apply(mk("post_rst_tie", 1,0,0,2,0, 1,0,0,3,0, 1,0, 0,0,0));
    apply(mk("post_rst_r1", 0,0,0,0,0, 1,0,0,3,0, 0,1, 0,0,0));
    apply(mk("post_rst_rd0", 1,0,0,0,0, 0,0,0,0,0, 1,0, 0,0,0));
    repeat (3) apply(idle);
    check("mem0 kept", mem[0], old0);
    check("scoreboard drained", 32'(sbq.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
